draw_phase_timer_bank: RTL and testbench
========================================

// Module: draw_phase_timer_bank
// PURPOSE
//  Parametrised bank of draw-phase countdown timers. Replaces the per-phase RateDivider + done-compare pairs.
//  The control FSM pulses start[i] for a draw phase.
//  The bank serialises requests: one phase runs at a time, lowest index first.
//  While phase i runs, the bank drives draw_en[i] to the datapath, then pulses done[i] for one cycle.
//  Per-channel lengths are runtime-writable. The bank also supports hold (pause) and abort.
// PARAMETERS
//  NUM_CH       10          number of draw-phase channels (>=2)
//  CNT_W        26          countdown width
//  CH_W         4           channel index width, >= clog2(NUM_CH)
//  DEFAULT_LEN  26'h00FFFF  reset value of every length register
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  start        in   NUM_CH  per-channel request pulses (any number per cycle)
//  len_wr_en    in   1       write len_wr_data into length register len_wr_ch
//  len_wr_ch    in   CH_W    length register index
//  len_wr_data  in   CNT_W   new length L (phase lasts L+1 counting edges)
//  hold         in   1       freeze countdown of active phase
//  abort        in   1       kill active phase without done
//  draw_en      out  NUM_CH  one-hot; bit active_ch high while state==RUN
//  done         out  NUM_CH  one-cycle pulse on completing channel
//  pending      out  NUM_CH  queued, not-yet-granted requests
//  busy         out  1       state != IDLE
//  active_ch    out  CH_W    channel currently granted
//  count        out  CNT_W   current countdown value
// BEHAVIOUR
//  Reset:
//   - state=IDLE; pending=0, count=0, active_ch=0; draw_en=0, done=0, busy=0.
//   - All len[i]=DEFAULT_LEN.
//  req = pending | start. start bits are OR'd into pending every edge unless granted that edge.
//  FSM: IDLE -> RUN -> DONE -> IDLE. All outputs decode from registered state; none combinational from inputs.
//   IDLE: if req!=0, grant lowest set index g:
//    - active_ch<=g, count<=len[g], pending[g]<=0, state<=RUN.
//    - Grant and first start occur on the same edge.
//   RUN: draw_en[active_ch]=1.
//    - abort: state<=IDLE, no done.
//    - else hold: count holds.
//    - else count==0: state<=DONE.
//    - else count<=count-1.
//   DONE: done[active_ch]=1 for exactly one cycle; draw_en=0.
//    - next edge state<=IDLE; abort here is a don't-care (done already shown).
//  Latency: with no hold, done rises L+1 edges after grant edge. L=0 gives done after 1 edge.
//   Minimum spacing between two grants is L+3 edges (one IDLE cycle between phases).
//  Priority each edge: reset > abort > hold > count.
//  Boundaries:
//   - start[i] while i is active: queued in pending; i re-runs afterwards.
//     Re-pulsing an already-pending channel has no extra effect (no counting of repeats).
//   - start for several channels in one cycle: lowest granted, rest stay pending.
//   - abort: pending untouched; start in abort cycle is still recorded. abort in IDLE: no effect.
//   - len write to the running channel affects only its next grant.
//     len_wr_ch>=NUM_CH: ignored. A write on the IDLE grant edge for the granted channel loads the OLD value.
//   - count never wraps: decrement only when count!=0.
//   - hold in DONE/IDLE: ignored.
// TESTING
//  T1 reset, len[3]=3, pulse start[3] at edge0 -> draw_en[3]=1 edges0-4; count 3,2,1,0; done[3] high only between edges 4 and 5.
//  T2 start[5] and start[2] same edge, L=1 each -> ch2 runs first, pending=0x020; ch5 granted one edge after done[2].
//  T3 len[0]=0, start[0] -> done[0] one edge after grant; busy low afterwards.
//  T4 len[1]=4, hold high 3 cycles mid-run -> count frozen 3 cycles; done[1] delayed by exactly 3 edges.
//  T5 abort at count=2 with start[6] same cycle -> IDLE, no done pulse, pending[6]=1, ch6 granted next edge.
//  T6 write len[4]=7 while ch4 running at L=2 -> current run ends after 3 edges; next start[4] runs 8 edges; write to ch 12 ignored.

Source files
------------

// File: rtl/draw_phase_timer_bank_if.sv
// Request/length/control bundle between the draw FSM and the phase timer bank.
// The master side issues requests and length writes; the slave side reports status.
interface draw_phase_timer_bank_if #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 26,
    parameter int CH_W   = 4
);
    logic [NUM_CH-1:0] start;
    logic              len_wr_en;
    logic [CH_W-1:0]   len_wr_ch;
    logic [CNT_W-1:0]  len_wr_data;
    logic              hold;
    logic              abort;
    logic [NUM_CH-1:0] draw_en;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] pending;
    logic              busy;
    logic [CH_W-1:0]   active_ch;
    logic [CNT_W-1:0]  count;

    modport master (
        output start, len_wr_en, len_wr_ch, len_wr_data, hold, abort,
        input  draw_en, done, pending, busy, active_ch, count
    );

    modport slave (
        input  start, len_wr_en, len_wr_ch, len_wr_data, hold, abort,
        output draw_en, done, pending, busy, active_ch, count
    );
endinterface

// File: rtl/draw_phase_timer_bank.sv
// Bank of draw-phase countdown timers: one phase runs at a time, lowest
// requesting channel first, with runtime lengths, hold and abort.
module draw_phase_timer_bank #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 26,
    parameter int CH_W   = 4,
    parameter logic [CNT_W-1:0] DEFAULT_LEN = 'h00FFFF
) (
    input logic clk,
    input logic reset,
    draw_phase_timer_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  len [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] draw_en_q;
    logic [NUM_CH-1:0] done_q;
    logic              busy_q;
    logic [CH_W-1:0]   active_q;
    logic [CNT_W-1:0]  count_q;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant_mask;
    logic [CH_W-1:0]   grant_ch;
    logic              grant_hit;

    assign req = pending_q | bus.start;

    // Scan high to low so the lowest set index wins.
    always_comb begin
        grant_mask = '0;
        grant_ch   = '0;
        grant_hit  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_mask    = '0;
                grant_mask[i] = 1'b1;
                grant_ch      = CH_W'(i);
                grant_hit     = 1'b1;
            end
        end
    end

    // A write on the grant edge lands after the grant reads the old length.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                len[i] <= DEFAULT_LEN;
            end
        end else if (bus.len_wr_en && (32'(bus.len_wr_ch) < NUM_CH)) begin
            len[bus.len_wr_ch] <= bus.len_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            draw_en_q <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            active_q  <= '0;
            count_q   <= '0;
        end else begin
            done_q    <= '0;
            pending_q <= req;
            unique case (state)
                IDLE: begin
                    if (grant_hit) begin
                        state     <= RUN;
                        active_q  <= grant_ch;
                        count_q   <= len[grant_ch];
                        pending_q <= req & ~grant_mask;
                        draw_en_q <= grant_mask;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        draw_en_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (bus.hold) begin
                        count_q <= count_q;
                    end else if (count_q == '0) begin
                        state     <= DONE;
                        draw_en_q <= '0;
                        done_q    <= draw_en_q;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    draw_en_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.draw_en   = draw_en_q;
    assign bus.done      = done_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = busy_q;
    assign bus.active_ch = active_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_draw_phase_timer_bank.sv
// Directed bench for draw_phase_timer_bank; done pulses are checked by a
// scoreboard monitor against channel and edge number queued by the stimulus.
module tb_draw_phase_timer_bank;
    localparam int NUM_CH = 10;
    localparam int CNT_W  = 26;
    localparam int CH_W   = 4;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    int   g;

    draw_phase_timer_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    draw_phase_timer_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(int ch, int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic set_len(int ch, int l);
        bus.len_wr_en   = 1'b1;
        bus.len_wr_ch   = CH_W'(ch);
        bus.len_wr_data = CNT_W'(l);
        @(negedge clk);
        bus.len_wr_en = 1'b0;
    endtask

    task automatic pulse_start(logic [NUM_CH-1:0] m);
        bus.start = m;
        @(negedge clk);
        bus.start = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every done pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset && bus.done != '0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0h required=none at_edge=%0d",
                         bus.done, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("done_ch", 32'(bus.done), 32'd1 << mon_e.ch);
                check("done_edge", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = '0;
        bus.len_wr_en   = 1'b0;
        bus.len_wr_ch   = '0;
        bus.len_wr_data = '0;
        bus.hold        = 1'b0;
        bus.abort       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_draw_en", 32'(bus.draw_en), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_active", 32'(bus.active_ch), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: L=3 on channel 3
        set_len(3, 3);
        pulse_start(10'h008);
        g = cyc;
        push(3, g + 4);
        check("t1_draw_en", 32'(bus.draw_en), 32'h008);
        check("t1_active", 32'(bus.active_ch), 32'd3);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_count", 32'(bus.count), 32'd3);
        for (int k = 2; k >= 0; k--) begin
            @(negedge clk);
            check("t1_count", 32'(bus.count), 32'(k));
            check("t1_draw_en", 32'(bus.draw_en), 32'h008);
        end
        @(negedge clk);
        check("t1_draw_en_done", 32'(bus.draw_en), 32'd0);
        wait_idle();

        // T2: simultaneous requests, lowest first, repeat pulse ignored
        set_len(2, 1);
        set_len(5, 1);
        pulse_start(10'h024);
        g = cyc;
        push(2, g + 2);
        push(5, g + 6);
        check("t2_active", 32'(bus.active_ch), 32'd2);
        check("t2_pending", 32'(bus.pending), 32'h020);
        pulse_start(10'h020);
        check("t2_pending_rep", 32'(bus.pending), 32'h020);
        repeat (2) @(negedge clk);
        check("t2_gap_busy", 32'(bus.busy), 32'd0);
        check("t2_gap_pending", 32'(bus.pending), 32'h020);
        @(negedge clk);
        check("t2_active5", 32'(bus.active_ch), 32'd5);
        check("t2_draw_en5", 32'(bus.draw_en), 32'h020);
        check("t2_pending0", 32'(bus.pending), 32'd0);
        wait_idle();

        // T3: L=0 finishes one edge after grant
        set_len(0, 0);
        pulse_start(10'h001);
        g = cyc;
        push(0, g + 1);
        check("t3_count", 32'(bus.count), 32'd0);
        check("t3_draw_en", 32'(bus.draw_en), 32'h001);
        repeat (2) @(negedge clk);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_draw_en_off", 32'(bus.draw_en), 32'd0);

        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_abort_pending", 32'(bus.pending), 32'd0);

        // T4: hold for three cycles delays done by three edges
        set_len(1, 4);
        pulse_start(10'h002);
        g = cyc;
        push(1, g + 8);
        check("t4_count", 32'(bus.count), 32'd4);
        @(negedge clk);
        check("t4_count", 32'(bus.count), 32'd3);
        bus.hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_count", 32'(bus.count), 32'd3);
        end
        bus.hold = 1'b0;
        wait_idle();

        // T5: abort at count 2 with a new request in the same cycle
        set_len(6, 1);
        set_len(7, 4);
        pulse_start(10'h080);
        repeat (2) @(negedge clk);
        check("t5_count", 32'(bus.count), 32'd2);
        bus.abort = 1'b1;
        bus.start = 10'h040;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = '0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_pending", 32'(bus.pending), 32'h040);
        check("t5_draw_en", 32'(bus.draw_en), 32'd0);
        @(negedge clk);
        g = cyc;
        push(6, g + 2);
        check("t5_active6", 32'(bus.active_ch), 32'd6);
        check("t5_draw_en6", 32'(bus.draw_en), 32'h040);
        check("t5_pending0", 32'(bus.pending), 32'd0);
        wait_idle();

        // T6: length writes while running, on the grant edge, and out of range
        set_len(4, 2);
        pulse_start(10'h010);
        g = cyc;
        push(4, g + 3);
        set_len(4, 7);
        set_len(12, 3);
        wait_idle();
        bus.start       = 10'h010;
        bus.len_wr_en   = 1'b1;
        bus.len_wr_ch   = CH_W'(4);
        bus.len_wr_data = CNT_W'(1);
        @(negedge clk);
        bus.start     = '0;
        bus.len_wr_en = 1'b0;
        g = cyc;
        push(4, g + 8);
        check("t6_count_old", 32'(bus.count), 32'd7);
        wait_idle();
        pulse_start(10'h010);
        g = cyc;
        push(4, g + 2);
        check("t6_count_new", 32'(bus.count), 32'd1);
        wait_idle();
        pulse_start(10'h004);
        g = cyc;
        push(2, g + 2);
        check("t6_ch2_len", 32'(bus.count), 32'd1);
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
